// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit pipelined core: instruction and data memories,
// an 8-byte MMIO window, and a boot loader that holds the core in reset while imem fills.
module cpu_mem_responder #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [15:0] dataAddr,
  input  logic [15:0] datain,
  input  logic [15:0] instrAddr,
  output logic [15:0] dataout,
  output logic [15:0] instruction,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  output logic        cpu_hold,
  output logic [15:0] gpio_out,
  output logic        err
);

  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [16:0] IMEM_LIM   = 17'(IMEM_WORDS);
  localparam logic [16:0] IMEM_BYTES = 17'(2 * IMEM_WORDS);
  localparam logic [16:0] DMEM_BYTES = 17'(2 * DMEM_WORDS);
  localparam logic [16:0] MMIO_LO    = {1'b0, MMIO_BASE};
  localparam logic [16:0] MMIO_HI    = MMIO_LO + 17'd8;

  // Loader handshake: a word transfers on every rising edge where load_valid and
  // load_ready are both high; load_ready is high only in LOAD outside reset.
  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] gpio_q, gpio_d;
  logic [15:0] cycle_q, cycle_d;
  logic [15:0] stores_q, stores_d;
  logic        err_q, err_d;

  logic [15:0] imem [IMEM_WORDS];
  logic [15:0] dmem [DMEM_WORDS];

  logic        in_load, in_run;
  logic        load_fire, load_in_range, imem_we;
  logic        instr_in_range;
  logic [16:0] daddr_ext;
  logic        mmio_hit, dmem_hit;
  logic [1:0]  reg_sel;
  logic [15:0] mmio_rdata;
  logic        rd_only, core_wr, gpio_we, dmem_we;
  logic        wr_bad, rd_bad, rdwr_bad;

  always_comb begin
    in_load    = (state_q == ST_LOAD) && !reset;
    in_run     = (state_q == ST_RUN) && !reset;
    load_ready = in_load;
    cpu_hold   = reset || (state_q == ST_LOAD);

    load_fire     = load_valid && in_load;
    load_in_range = ({1'b0, load_addr} < IMEM_LIM);
    imem_we       = load_fire && load_in_range;

    instr_in_range = ({1'b0, instrAddr} < IMEM_BYTES);
    instruction    = (in_run && instr_in_range) ? imem[instrAddr[IW:1]] : 16'h0000;

    // MMIO window decodes ahead of DMEM; byte offset bit 0 is ignored.
    daddr_ext = {1'b0, dataAddr};
    mmio_hit  = (daddr_ext >= MMIO_LO) && (daddr_ext < MMIO_HI);
    dmem_hit  = !mmio_hit && (daddr_ext < DMEM_BYTES);
    reg_sel   = dataAddr[2:1] - MMIO_BASE[2:1] - {1'b0, (~dataAddr[0] & MMIO_BASE[0])};

    case (reg_sel)
      2'd0:    mmio_rdata = gpio_q;
      2'd1:    mmio_rdata = cycle_q;
      2'd2:    mmio_rdata = stores_q;
      default: mmio_rdata = {14'd0, in_run, err_q};
    endcase

    rd_only = MemRd && !MemWr;
    dataout = 16'h0000;
    if (in_run && rd_only) begin
      if (mmio_hit)      dataout = mmio_rdata;
      else if (dmem_hit) dataout = dmem[dataAddr[DW:1]];
    end

    core_wr  = in_run && MemWr;
    gpio_we  = core_wr && mmio_hit && (reg_sel == 2'd0);
    dmem_we  = core_wr && dmem_hit;
    wr_bad   = core_wr && !gpio_we && !dmem_we;
    rdwr_bad = in_run && MemRd && MemWr;
    rd_bad   = in_run && rd_only && !mmio_hit && !dmem_hit;

    state_d = state_q;
    if (state_q == ST_LOAD && load_done) state_d = ST_RUN;

    gpio_d   = gpio_we ? datain : gpio_q;
    cycle_d  = in_run ? cycle_q + 16'd1 : cycle_q;
    stores_d = (gpio_we || dmem_we) ? stores_q + 16'd1 : stores_q;
    err_d    = err_q || (load_fire && !load_in_range) || wr_bad || rd_bad || rdwr_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      gpio_q   <= 16'h0000;
      cycle_q  <= 16'h0000;
      stores_q <= 16'h0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      err_q    <= err_d;
    end
  end

  // Memory contents survive reset so a re-held core restarts on the same image.
  always_ff @(posedge clk) begin
    if (imem_we) imem[load_addr[IW-1:0]] <= load_data;
    if (dmem_we) dmem[dataAddr[DW:1]] <= datain;
  end

  assign gpio_out = gpio_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a spec-level model.
module tb_cpu_mem_responder;
  logic        clk = 1'b0;
  logic        reset, MemRd, MemWr, load_valid, load_done;
  logic [15:0] dataAddr, datain, instrAddr, load_addr, load_data;
  logic [15:0] dataout, instruction, gpio_out;
  logic        load_ready, cpu_hold, err;

  int checks = 0;
  int errors = 0;

  logic [15:0] img [256];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] daddr;
    logic [15:0] din;
    logic [15:0] iaddr;
    logic [15:0] exp_dout;
    logic [15:0] exp_instr;
    logic [15:0] exp_gpio;
    logic        exp_err;
  } vec_t;
  vec_t vecs [16];

  // model state for the random phase
  bit          m_run;
  logic [15:0] m_gpio, m_cycle, m_stores;
  logic        m_err;
  logic [15:0] m_dmem [256];
  bit          m_known [256];

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .dataAddr(dataAddr), .datain(datain), .instrAddr(instrAddr),
    .dataout(dataout), .instruction(instruction),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .cpu_hold(cpu_hold),
    .gpio_out(gpio_out), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    MemRd = 1'b0; MemWr = 1'b0; dataAddr = 16'h0; datain = 16'h0; instrAddr = 16'h0;
    load_valid = 1'b0; load_addr = 16'h0; load_data = 16'h0; load_done = 1'b0;
  endtask

  task automatic restart();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic err_case(input string nm, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] din,
                          input logic [15:0] exp_dout, input logic exp_err);
    restart();
    MemRd = rd; MemWr = wr; dataAddr = addr; datain = din;
    #2;
    chk({nm, " dout"}, dataout, exp_dout);
    chk({nm, " err_before"}, 16'(err), 16'h0);
    tick();
    idle();
    #1;
    chk({nm, " err_after"}, 16'(err), 16'(exp_err));
  endtask

  function automatic logic [15:0] m_read(input int a, output bit known);
    known = 1'b1;
    if (a >= 'hFF00 && a < 'hFF08) begin
      case ((a - 'hFF00) / 2)
        0:       return m_gpio;
        1:       return m_cycle;
        2:       return m_stores;
        default: return {14'd0, 1'b1, m_err};
      endcase
    end else if (a / 2 < 256) begin
      known = m_known[a / 2];
      return m_dmem[a / 2];
    end
    return 16'h0000;
  endfunction

  initial begin
    bit          r_rst, dknown;
    int          k, sel, a, ia, la;
    logic [15:0] e_dout, e_instr;
    logic        e_hold, e_ready;

    for (int i = 0; i < 256; i++) img[i] = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(16'hA000 + i);

    vecs[0]  = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h0006, 16'h0000, 16'h4444, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h000A, 16'h0001, 16'hA005, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h01FE, 16'hBEEF, 16'hA0FF, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'hFF04, 16'h0000, 16'h0001, 16'h0001, 16'h1111, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h0004, 16'h0002, 16'h3333, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'hFF00, 16'h00A5, 16'h0002, 16'h0000, 16'h2222, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h00A5, 16'h1111, 16'h00A5, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'hFF01, 16'h005A, 16'h0000, 16'h0000, 16'h1111, 16'h00A5, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'hFF04, 16'h0000, 16'h0000, 16'h0003, 16'h1111, 16'h005A, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h01FE, 16'h7777, 16'h0000, 16'h0000, 16'h1111, 16'h005A, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 16'h0000, 16'h7777, 16'h1111, 16'h005A, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h0200, 16'h9999, 16'h0000, 16'h0000, 16'h1111, 16'h005A, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h0000, 16'h0003, 16'h1111, 16'h005A, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'hFF04, 16'h0000, 16'h0000, 16'h0004, 16'h1111, 16'h005A, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 16'h000F, 16'h1111, 16'h005A, 1'b1};

    // reset state
    idle();
    reset = 1'b1;
    tick();
    tick();
    MemRd = 1'b1; dataAddr = 16'hFF06; instrAddr = 16'h0006;
    #2;
    chk("rst cpu_hold", 16'(cpu_hold), 16'h1);
    chk("rst load_ready", 16'(load_ready), 16'h0);
    chk("rst gpio", gpio_out, 16'h0);
    chk("rst err", 16'(err), 16'h0);
    chk("rst dataout", dataout, 16'h0);
    chk("rst instruction", instruction, 16'h0);
    reset = 1'b0;
    #2;
    chk("load load_ready", 16'(load_ready), 16'h1);
    chk("load cpu_hold", 16'(cpu_hold), 16'h1);
    chk("load dataout", dataout, 16'h0);
    chk("load instruction", instruction, 16'h0);

    // image load; core accesses during LOAD must be ignored
    MemRd = 1'b1; MemWr = 1'b1; dataAddr = 16'hFF00; datain = 16'hFFFF;
    for (int n = 0; n < 256; n++) begin
      la = (n < 252) ? n + 4 : n - 252;
      load_valid = 1'b1; load_addr = 16'(la); load_data = img[la];
      load_done = (n == 255);
      tick();
    end

    // directed table in RUN; a loader word held valid must be ignored
    idle();
    load_valid = 1'b1; load_addr = 16'd5; load_data = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      MemRd = vecs[i].rd; MemWr = vecs[i].wr; dataAddr = vecs[i].daddr;
      datain = vecs[i].din; instrAddr = vecs[i].iaddr;
      #2;
      chk($sformatf("vec%0d dataout", i), dataout, vecs[i].exp_dout);
      chk($sformatf("vec%0d instruction", i), instruction, vecs[i].exp_instr);
      chk($sformatf("vec%0d gpio", i), gpio_out, vecs[i].exp_gpio);
      chk($sformatf("vec%0d err", i), 16'(err), 16'(vecs[i].exp_err));
      chk($sformatf("vec%0d cpu_hold", i), 16'(cpu_hold), 16'h0);
      tick();
    end

    // reset mid-RUN: registers clear, image kept
    idle();
    reset = 1'b1; MemRd = 1'b1; dataAddr = 16'hFF00;
    #2;
    chk("midrun rst cpu_hold", 16'(cpu_hold), 16'h1);
    chk("midrun rst load_ready", 16'(load_ready), 16'h0);
    chk("midrun rst dataout", dataout, 16'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrun gpio", gpio_out, 16'h0);
    chk("midrun err", 16'(err), 16'h0);
    chk("midrun cpu_hold", 16'(cpu_hold), 16'h1);
    load_done = 1'b1;
    tick();
    idle();
    #1;
    chk("midrun instr0", instruction, 16'h1111);
    chk("midrun run cpu_hold", 16'(cpu_hold), 16'h0);

    // loader range: 255 accepted, 300 dropped with err and no aliasing
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_valid = 1'b1; load_addr = 16'd255; load_data = 16'h5AFF;
    tick();
    #1;
    chk("ld255 err", 16'(err), 16'h0);
    load_addr = 16'd300; load_data = 16'hFFFF;
    tick();
    load_valid = 1'b0;
    #1;
    chk("ld300 err", 16'(err), 16'h1);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    img[255] = 16'h5AFF;
    instrAddr = 16'h01FE;
    #1;
    chk("ld255 instr", instruction, 16'h5AFF);
    instrAddr = 16'h0058;
    #1;
    chk("ld300 no alias", instruction, 16'hA02C);

    // index 256 dropped; reset mid-LOAD restarts cleanly
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_valid = 1'b1; load_addr = 16'd256; load_data = 16'hFFFF;
    tick();
    load_valid = 1'b0;
    #1;
    chk("ld256 err", 16'(err), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midload err", 16'(err), 16'h0);
    chk("midload load_ready", 16'(load_ready), 16'h1);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    #1;
    chk("ld256 no alias", instruction, 16'h1111);

    // single-access error cases, each from a clean RUN start
    err_case("wr_cycle", 1'b0, 1'b1, 16'hFF02, 16'h1234, 16'h0000, 1'b1);
    MemRd = 1'b1; dataAddr = 16'hFF06;
    #1;
    chk("status after ro write", dataout, 16'h0003);
    err_case("wr_stores", 1'b0, 1'b1, 16'hFF04, 16'h1234, 16'h0000, 1'b1);
    err_case("wr_status", 1'b0, 1'b1, 16'hFF07, 16'h1234, 16'h0000, 1'b1);
    err_case("wr_oor", 1'b0, 1'b1, 16'hFEFE, 16'h1234, 16'h0000, 1'b1);
    err_case("rd_oor", 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1);
    err_case("rd_mmio_end", 1'b1, 1'b0, 16'hFF08, 16'h0000, 16'h0000, 1'b1);
    err_case("rd_top", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    err_case("wr_gpio", 1'b0, 1'b1, 16'hFF00, 16'h0042, 16'h0000, 1'b0);
    chk("wr_gpio value", gpio_out, 16'h0042);
    err_case("rd_dmem", 1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0);
    err_case("rdwr", 1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b1);
    MemRd = 1'b1; dataAddr = 16'h0020;
    #1;
    chk("rdwr readback", dataout, 16'h1234);
    MemRd = 1'b1; dataAddr = 16'hFF04;
    #1;
    chk("rdwr stores", dataout, 16'h0001);

    // cycle counter wrap
    restart();
    MemRd = 1'b1; dataAddr = 16'hFF02;
    #1;
    chk("cycle start", dataout, 16'h0000);
    for (int n = 0; n < 65535; n++) tick();
    #1;
    chk("cycle ffff", dataout, 16'hFFFF);
    tick();
    #1;
    chk("cycle wrap", dataout, 16'h0000);

    // randomized traffic against the model
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      r_rst = (n == 0) || ($urandom_range(0, 299) == 0);
      reset = r_rst;
      load_valid = 1'($urandom_range(0, 1));
      load_addr = 16'($urandom_range(0, 299));
      load_data = 16'($urandom);
      load_done = ($urandom_range(0, 15) == 0);
      k = $urandom_range(0, 9);
      MemRd = (k < 4) || (k == 9);
      MemWr = (k >= 4 && k < 8) || (k == 9);
      sel = $urandom_range(0, 9);
      if (sel < 5)       dataAddr = 16'($urandom_range(0, 63));
      else if (sel < 7)  dataAddr = 16'(16'hFF00 + $urandom_range(0, 7));
      else if (sel == 7) dataAddr = 16'(16'h01FE + $urandom_range(0, 3));
      else if (sel == 8) dataAddr = 16'(16'hFEFC + $urandom_range(0, 15));
      else               dataAddr = 16'($urandom);
      datain = 16'($urandom);
      instrAddr = 16'($urandom_range(0, 16'h03FF));
      #2;
      a = int'(dataAddr);
      ia = int'(instrAddr);
      la = int'(load_addr);
      dknown = 1'b1;
      e_dout = 16'h0;
      e_instr = 16'h0;
      if (r_rst) begin
        e_hold = 1'b1; e_ready = 1'b0;
      end else if (!m_run) begin
        e_hold = 1'b1; e_ready = 1'b1;
      end else begin
        e_hold = 1'b0; e_ready = 1'b0;
        if (ia / 2 < 256) e_instr = img[ia / 2];
        if (MemRd && !MemWr) e_dout = m_read(a, dknown);
      end
      chk($sformatf("rnd%0d cpu_hold", n), 16'(cpu_hold), 16'(e_hold));
      chk($sformatf("rnd%0d load_ready", n), 16'(load_ready), 16'(e_ready));
      chk($sformatf("rnd%0d instruction", n), instruction, e_instr);
      chk($sformatf("rnd%0d gpio", n), gpio_out, m_gpio);
      chk($sformatf("rnd%0d err", n), 16'(err), 16'(m_err));
      if (dknown) chk($sformatf("rnd%0d dataout", n), dataout, e_dout);

      if (r_rst) begin
        m_run = 1'b0; m_gpio = 16'h0; m_cycle = 16'h0; m_stores = 16'h0; m_err = 1'b0;
      end else if (!m_run) begin
        if (load_valid) begin
          if (la < 256) img[la] = load_data;
          else          m_err = 1'b1;
        end
        if (load_done) m_run = 1'b1;
      end else begin
        m_cycle = m_cycle + 16'd1;
        if (MemWr) begin
          if (a >= 'hFF00 && a < 'hFF08) begin
            if ((a - 'hFF00) / 2 == 0) begin
              m_gpio = datain;
              m_stores = m_stores + 16'd1;
            end else m_err = 1'b1;
          end else if (a / 2 < 256) begin
            m_dmem[a / 2] = datain;
            m_known[a / 2] = 1'b1;
            m_stores = m_stores + 16'd1;
          end else m_err = 1'b1;
        end
        if (MemRd && MemWr) m_err = 1'b1;
        if (MemRd && !MemWr && !(a >= 'hFF00 && a < 'hFF08) && a / 2 >= 256) m_err = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 16-bit pipelined CPU core. Serves the core's instruction-fetch port (instrAddr -> instruction) and data port (MemRd/MemWr, dataAddr, datain -> dataout).
- Owns the instruction memory, the data memory and a small memory-mapped I/O (MMIO) window.
- Contains a boot-loader FSM that fills instruction memory over a valid/ready handshake while holding the core in reset.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 16-bit words.
- DMEM_WORDS, 256, data memory depth in 16-bit words.
- MMIO_BASE, 16'hFF00, byte address of the MMIO window; the window is 8 bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- MemRd  in  1  core data read strobe.
- MemWr  in  1  core data write strobe.
- dataAddr  in  16  core data byte address.
- datain  in  16  core store data.
- instrAddr  in  16  core fetch byte address.
- dataout  out  16  load data returned to the core.
- instruction  out  16  fetched instruction word.
- load_valid  in  1  loader word valid.
- load_addr  in  16  loader word index.
- load_data  in  16  loader instruction word.
- load_ready  out  1  loader may transfer.
- load_done  in  1  end-of-image pulse.
- cpu_hold  out  1  core must be held in reset; ORed externally into the core reset.
- gpio_out  out  16  MMIO GPIO register.
- err  out  1  sticky access-error flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FSM state = LOAD, cpu_hold=1, load_ready=0 during the reset cycle, gpio_out=0, cycle counter=0, store counter=0, err=0, dataout=0, instruction=0. Memory arrays are not cleared by reset.
- FSM states:
  - LOAD: cpu_hold=1, load_ready=1. Each cycle with load_valid&load_ready writes imem[load_addr] <= load_data on that edge.
    - If load_addr >= IMEM_WORDS, the write is dropped and err is set.
    - load_done moves the FSM to RUN on the next edge. A word presented in the same cycle as load_done is still written.
  - RUN: cpu_hold=0, load_ready=0, load_valid is ignored. The FSM stays in RUN until reset.
  - Reset asserted mid-RUN: the FSM returns to LOAD and the instruction image is retained. Reset asserted mid-LOAD: the FSM restarts LOAD.
- Addressing: all core addresses are byte addresses; word index = addr[15:1]. addr[0] is ignored, with no error.
- Fetch: instruction = imem[instrAddr[15:1]], combinational, same cycle.
  - Index >= IMEM_WORDS returns 16'h0000 (NOP encoding).
  - instruction is forced to 0 while in LOAD.
- Data read (MemRd=1, MemWr=0): dataout is combinational, same cycle.
  - A DMEM index in range returns dmem[idx].
  - The MMIO window returns the register value.
  - Anything else returns 0 and sets err on the edge.
  - When MemRd=0, dataout=0.
- Data write (MemWr=1): committed on the rising edge.
  - Out-of-range writes are dropped and set err.
  - Writes to read-only MMIO registers are dropped and set err.
- Simultaneous MemRd and MemWr: the write is performed, dataout=0, and err is set.
- Core accesses in LOAD are ignored: no write, dataout=0, no err.
- MMIO map (byte offsets from MMIO_BASE):
  - +0 GPIO, R/W; gpio_out updates on the write edge.
  - +2 CYCLE, RO; increments every RUN cycle and wraps 16'hFFFF -> 0.
  - +4 STORES, RO; increments on every accepted DMEM or GPIO write, wraps.
  - +6 STATUS, RO; bit0=err, bit1=RUN, other bits 0.
- Counter sampling: a read of CYCLE returns the pre-increment value of that cycle.
- Address decode priority: MMIO window first, then DMEM (index < DMEM_WORDS).
- err clears only on reset.

Test Plan:
- Load test: load words 0..3 = 16'h1111,16'h2222,16'h3333,16'h4444 with load_done on the 4th word -> FSM in RUN next cycle, cpu_hold=0; instrAddr=16'h0006 gives instruction=16'h4444; instrAddr=16'h0200 gives 16'h0000.
- Store/load test: MemWr at dataAddr 16'h0010 with datain 16'hBEEF, then MemRd at 16'h0011 -> dataout=16'hBEEF; STORES reads 1, err=0.
- MMIO test: write 16'h00A5 to 16'hFF00 -> gpio_out=16'h00A5 next cycle; write to 16'hFF02 -> dropped, err=1, STATUS reads 16'h0003.
- Error test: load_addr=300 in LOAD -> err=1, imem unchanged. MemRd&MemWr to 16'h0020 with 16'h1234 -> dataout=0, a later read returns 16'h1234.
- Wrap and reset test: run 65536 RUN cycles -> CYCLE returns 0. Assert reset mid-RUN -> cpu_hold=1, gpio_out=0, err=0, and instruction memory still returns 16'h1111 at address 0 after the next load_done.
